tdm_mux4: RTL and testbench
===========================

Name: tdm_mux4

Overview:
- 4-to-1 time-division multiplexer; the transmit end that feeds a 1-to-4 select demux.
- Four input channels each offer a word with a valid/ready handshake. A round-robin arbiter picks one word per transfer and places it in a single output register, tagged with its 2-bit channel select.
- The downstream demux routes the word using the tag: s1 = out_sel[1], s2 = out_sel[0].

Parameters:
- WIDTH, 8, data width of every channel and of the output word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  enable; 0 blocks new grants.
- in0  input  WIDTH  channel 0 data.
- in1  input  WIDTH  channel 1 data.
- in2  input  WIDTH  channel 2 data.
- in3  input  WIDTH  channel 3 data.
- v  input  4  per-channel valid; v[n] belongs to channel n.
- rdy  output  4  per-channel ready (grant), combinational, at most one bit set.
- out_data  output  WIDTH  registered output word.
- out_sel  output  2  registered channel tag (00=ch0 ... 11=ch3).
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=00, round-robin pointer ptr=0, rdy=0000. Reset mid-transfer drops the held word with no output.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot free: space = ~out_valid | out_ready.
- Grant condition: en & space & (|v). When true, the winner is the first n with v[n]=1, searching ptr, ptr+1, ... (mod 4). rdy[winner]=1 combinationally; all other rdy bits are 0.
- On a grant at clock edge k:
  - out_data <= in[winner], out_sel <= winner, out_valid <= 1.
  - ptr <= winner+1 (mod 4; 3 wraps to 0).
  - Latency: 1 cycle from handshake to out_valid.
- Same-cycle drain and grant: in FULL with out_ready=1 and a grant, the old word is consumed and the new word is loaded in the same edge. Sustained throughput is 1 word/cycle.
- No grant and out_ready=1 in FULL: out_valid <= 0 (go to EMPTY). out_data and out_sel hold their last values.
- FULL with out_ready=0: out_data, out_sel and out_valid are frozen; rdy=0000 regardless of v.
- en=0: rdy=0000. A held word still drains normally on out_ready. ptr does not change.
- ptr advances only on a grant.
- Fairness: with all four v high continuously, grant order is 0,1,2,3,0,...
- A channel that drops v before its grant loses no state. No combinational path from out_data to rdy; rdy depends only on v, en, out_valid, out_ready and ptr.

Optional Feature:
- Macro TDM_MUX_PARITY_EN adds output port out_par (1 bit, registered).
  - out_par <= ^{out_sel, in[winner]}, loaded with each word.
  - Reset value 0; holds its value with out_data.
- Without the macro the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 with v=1111 -> rdy=0000, out_valid=0, out_data=0, out_sel=00. Release rst, en=1, out_ready=1 -> rdy=0001, next cycle out_sel=00.
- Single channel: v=0100, in2=8'hA5, en=1, out_ready=1 -> rdy=0100 in the same cycle; next cycle out_valid=1, out_data=A5, out_sel=10.
- Round-robin: v=1111 held, out_ready=1 for 8 cycles -> out_sel sequence 00,01,10,11,00,01,10,11 with out_valid continuously 1.
- Backpressure: word 8'h3C from ch1 held with out_ready=0 for 5 cycles and v=1111 -> out_data stays 3C, out_sel stays 01, rdy=0000. Raise out_ready -> next word comes from ch2.
- Enable gating: en=0, v=1000, out_valid=0 -> rdy=0000 and out_valid stays 0 for 4 cycles. Raise en -> rdy=1000, then out_sel=11.
- Parity (TDM_MUX_PARITY_EN defined): in3=8'h01 granted -> out_sel=11, out_par=1 (bits 1,1,1).

Source files
------------

// File: rtl/tdm_mux4.sv
// 4-to-1 time-division multiplexer: round-robin arbitration of four valid/ready
// channels into one registered, channel-tagged output word. Define
// TDM_MUX_PARITY_EN to add the registered out_par port.
module tdm_mux4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [3:0]       v,
   output logic [3:0]       rdy,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel,
   output logic             out_valid,
   input  logic             out_ready
`ifdef TDM_MUX_PARITY_EN
   ,
   output logic             out_par
`endif
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [1:0]       ptr_r;
   logic [1:0]       ptr_nx_s;
   logic [WIDTH-1:0] data_r;
   logic [1:0]       sel_r;
   logic             load_s;
   logic             space_s;
   logic             grant_s;
   logic [3:0]       v_rot_s;
   logic [1:0]       offset_s;
   logic [1:0]       winner_s;
   logic [WIDTH-1:0] win_data_s;

   function automatic logic word_parity(input logic [1:0] sel, input logic [WIDTH-1:0] data);
      return ^{sel, data};
   endfunction

   // The slot is free when empty or when the held word leaves this cycle.
   assign space_s = (state_r == EMPTY) | out_ready;
   assign grant_s = ~rst & en & space_s & (|v);

   // Rotate valids so that bit 0 is the channel the pointer names.
   always_comb begin
      v_rot_s = v;
      case (ptr_r)
         2'd0:    v_rot_s = v;
         2'd1:    v_rot_s = {v[0], v[3:1]};
         2'd2:    v_rot_s = {v[1:0], v[3:2]};
         2'd3:    v_rot_s = {v[2:0], v[3]};
         default: v_rot_s = v;
      endcase
   end

   // Priority-encode the rotated valids; winner wraps modulo 4.
   always_comb begin
      offset_s = 2'd3;
      if (v_rot_s[0]) begin
         offset_s = 2'd0;
      end else if (v_rot_s[1]) begin
         offset_s = 2'd1;
      end else if (v_rot_s[2]) begin
         offset_s = 2'd2;
      end else begin
         offset_s = 2'd3;
      end
      winner_s = ptr_r + offset_s;
   end

   // Ready decode and winning data select; rdy never looks at data.
   always_comb begin
      rdy        = 4'b0000;
      win_data_s = in0;
      case (winner_s)
         2'd0:    win_data_s = in0;
         2'd1:    win_data_s = in1;
         2'd2:    win_data_s = in2;
         2'd3:    win_data_s = in3;
         default: win_data_s = in0;
      endcase
      if (grant_s) begin
         rdy[winner_s] = 1'b1;
      end else begin
         rdy = 4'b0000;
      end
   end

   // Next state: a grant always loads; otherwise a drained word empties the slot.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      case (state_r)
         EMPTY: begin
            if (grant_s) begin
               state_nx_s = FULL;
               load_s     = 1'b1;
            end else begin
               state_nx_s = EMPTY;
            end
         end
         FULL: begin
            if (grant_s) begin
               state_nx_s = FULL;
               load_s     = 1'b1;
            end else if (out_ready) begin
               state_nx_s = EMPTY;
            end else begin
               state_nx_s = FULL;
            end
         end
         default: begin
            state_nx_s = EMPTY;
            load_s     = 1'b0;
         end
      endcase
   end

   // Pointer moves past the winner only when a grant happens.
   always_comb begin
      if (grant_s) begin
         ptr_nx_s = winner_s + 2'd1;
      end else begin
         ptr_nx_s = ptr_r;
      end
   end

   // State and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= EMPTY;
         ptr_r   <= 2'd0;
      end else begin
         state_r <= state_nx_s;
         ptr_r   <= ptr_nx_s;
      end
   end

   // Output word register; holds its contents when nothing is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= {WIDTH{1'b0}};
         sel_r  <= 2'd0;
      end else if (load_s) begin
         data_r <= win_data_s;
         sel_r  <= winner_s;
      end else begin
         data_r <= data_r;
         sel_r  <= sel_r;
      end
   end

`ifdef TDM_MUX_PARITY_EN
   logic par_r;

   // Parity covers the tag and the word, loaded alongside them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_r <= 1'b0;
      end else if (load_s) begin
         par_r <= word_parity(winner_s, win_data_s);
      end else begin
         par_r <= par_r;
      end
   end

   assign out_par = par_r;
`endif

   assign out_data  = data_r;
   assign out_sel   = sel_r;
   assign out_valid = (state_r == FULL);

endmodule

// File: tb/tb_tdm_mux4.sv
// Scoreboard bench for tdm_mux4: directed vectors push expected words, a
// negedge monitor compares whatever the output register presents.
module tb_tdm_mux4;

   typedef struct packed {
      logic       par;
      logic [1:0] sel;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic [7:0] in0 = 8'h00;
   logic [7:0] in1 = 8'h00;
   logic [7:0] in2 = 8'h00;
   logic [7:0] in3 = 8'h00;
   logic [3:0] v = 4'b1111;
   logic [3:0] rdy;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic       out_valid;
   logic       out_ready = 1'b1;
`ifdef TDM_MUX_PARITY_EN
   logic       out_par;
`endif

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   tdm_mux4 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .v         (v),
      .rdy       (rdy),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
`ifdef TDM_MUX_PARITY_EN
      .out_par   (out_par),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; exp_rdy is the hand-computed grant for these inputs.
   task automatic step(input logic e, input logic [3:0] vv, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                       input logic ordy, input logic [3:0] exp_rdy, input string nm);
      exp_t x;
      en = e; v = vv; in0 = d0; in1 = d1; in2 = d2; in3 = d3; out_ready = ordy;
      @(negedge clk);
      check(nm, {28'd0, rdy}, {28'd0, exp_rdy});
      if (exp_rdy != 4'b0000) begin
         case (exp_rdy)
            4'b0001: begin x.sel = 2'd0; x.data = d0; end
            4'b0010: begin x.sel = 2'd1; x.data = d1; end
            4'b0100: begin x.sel = 2'd2; x.data = d2; end
            default: begin x.sel = 2'd3; x.data = d3; end
         endcase
         x.par = ^{x.sel, x.data};
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented word must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            check("out_data", {24'd0, out_data}, {24'd0, sb[0].data});
            check("out_sel", {30'd0, out_sel}, {30'd0, sb[0].sel});
`ifdef TDM_MUX_PARITY_EN
            check("out_par", {31'd0, out_par}, {31'd0, sb[0].par});
`endif
            if (out_ready) begin
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      // Reset with all channels requesting.
      @(negedge clk);
      check("rst_rdy", {28'd0, rdy}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
      check("rst_sel", {30'd0, out_sel}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, "post_rst_rdy");
      step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, "idle_rdy");

      // Single channel 2, pointer at 1.
      step(1'b1, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, 4'b0100, "single_rdy");
      step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, "idle_rdy");

      // Pointer at 3: grant ch3 returns pointer to 0, then full round robin.
      step(1'b1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h77, 1'b1, 4'b1000, "ch3_rdy");
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         logic [3:0] oh;
         b  = 8'(8'h10 * (i + 1));
         oh = 4'b0001 << (i % 4);
         step(1'b1, 4'b1111, b, b + 8'd1, b + 8'd2, b + 8'd3, 1'b1, oh, "rr_rdy");
      end

      // Backpressure: 3C from ch1 held for five cycles, then ch2 next.
      step(1'b1, 4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b1, 4'b0010, "bp_load_rdy");
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b0, 4'b0000, "bp_hold_rdy");
      end
      step(1'b1, 4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1, 4'b0100, "bp_release_rdy");
      step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, "idle_rdy");

      // Enable gating with an empty slot, then ch3 word 01 (parity 1).
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 4'b0000, "en_off_rdy");
         check("en_off_valid", {31'd0, out_valid}, 32'd0);
      end
      step(1'b1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 4'b1000, "en_on_rdy");
      step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, "idle_rdy");

      // Drained slot keeps its last word and tag.
      @(negedge clk);
      check("drain_valid", {31'd0, out_valid}, 32'd0);
      check("hold_data", {24'd0, out_data}, 32'h01);
      check("hold_sel", {30'd0, out_sel}, 32'd3);
      @(posedge clk);
      #1;

      // Reset while a word is held drops it.
      step(1'b1, 4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0001, "pre_rst_rdy");
      v = 4'b1111;
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_data", {24'd0, out_data}, 32'd0);
      check("mid_rst_rdy", {28'd0, rdy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, "final_idle_rdy");
      check("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
